// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback steps and drives the datapath enables.
// Ports:
//   clk, reset (async, active high), opcode (IR[31:26]), mem_ready (memory done)
//   PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite
//   ALUSrcA, ALUSrcB[1:0], PCSrc[1:0], ALUopcode[1:0], illegal_op, state[3:0] (debug)
module mips_multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int OP_W          = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            Branch,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSrc,
  output logic [1:0]      ALUopcode,
  output logic            illegal_op,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  state_t r_state;
  state_t w_next;
  logic   w_ready;
  logic   w_legal;

  // Without the handshake every memory access completes in one cycle.
  assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state   = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_legal = 1'b1;
    w_next  = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next  = S_FETCH;
            w_legal = 1'b0;
          end
        endcase
      end
      S_MEMADR:  w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next = S_ALUWB;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // All outputs held low while reset is high, so an in-flight write
  // is cancelled asynchronously.
  always_comb begin
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUopcode  = 2'b00;
    illegal_op = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = w_ready;
          PCWrite = w_ready;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = ~w_legal;
        end
        S_MEMADR, S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA   = 1'b1;
          ALUopcode = 2'b10;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA   = 1'b1;
          ALUopcode = 2'b01;
          Branch    = 1'b1;
          PCSrc     = 2'b01;
        end
        S_ADDIWB:  RegWrite = 1'b1;
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// Table-driven reference model, directed sequences, random stimulus, async reset.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b1;
  logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc, ALUopcode;
  logic       illegal_op;
  logic [3:0] state;

  int n_err = 0;
  int n_chk = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUopcode(ALUopcode),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Reference: step tables plus per-step output vectors.
  int            m_st;
  int            dec_tbl[64];
  int            succ[16];
  bit            is_wait[16];
  logic [15:0]   exp_out[16];
  logic [5:0]    legal_ops[6];

  // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUopcode}
  function automatic logic [15:0] mk(
    bit pcw, bit br, bit iord, bit mr, bit mw, bit irw, bit m2r,
    bit rd, bit rw, bit sa, logic [1:0] sb, logic [1:0] ps, logic [1:0] ao);
    return {pcw, br, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, ao};
  endfunction

  function automatic logic [15:0] obs_out();
    return {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUopcode};
  endfunction

  function automatic int m_next(int s, logic [5:0] op, bit rdy);
    if (s == 1) return dec_tbl[op];
    if (s == 2) return (op == 6'h23) ? 3 : 5;
    if (is_wait[s] && !rdy) return s;
    return succ[s];
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_now(input logic [5:0] op, input bit rdy);
    logic [15:0] e;
    bit          ill;
    e = exp_out[m_st];
    if (m_st == 0 && rdy) begin
      e[15] = 1'b1;
      e[10] = 1'b1;
    end
    ill = (m_st == 1) && (dec_tbl[op] == 0);
    chk("state", int'(state), m_st);
    chk("outs", int'(obs_out()), int'(e));
    chk("illegal", int'(illegal_op), int'(ill));
  endtask

  task automatic cyc(input logic [5:0] op, input bit rdy);
    int nx;
    opcode    = op;
    mem_ready = rdy;
    @(negedge clk);
    check_now(op, rdy);
    nx = m_next(m_st, op, rdy);
    @(posedge clk);
    #1;
    m_st = nx;
  endtask

  initial begin
    logic [5:0] rop;
    for (int i = 0; i < 64; i++) dec_tbl[i] = 0;
    dec_tbl[6'h23] = 2; dec_tbl[6'h2B] = 2; dec_tbl[6'h00] = 6;
    dec_tbl[6'h04] = 8; dec_tbl[6'h08] = 9; dec_tbl[6'h02] = 11;
    legal_ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    for (int i = 0; i < 16; i++) begin
      succ[i] = 0;
      is_wait[i] = 1'b0;
      exp_out[i] = '0;
    end
    succ[0] = 1; succ[3] = 4; succ[6] = 7; succ[9] = 10;
    is_wait[0] = 1'b1; is_wait[3] = 1'b1; is_wait[5] = 1'b1;
    exp_out[0]  = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00);
    exp_out[1]  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
    exp_out[2]  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    exp_out[3]  = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
    exp_out[4]  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
    exp_out[5]  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
    exp_out[6]  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10);
    exp_out[7]  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
    exp_out[8]  = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
    exp_out[9]  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    exp_out[10] = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
    exp_out[11] = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00);

    // Reset held: everything low even with mem_ready high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_outs", int'(obs_out()), 0);
    chk("rst_illegal", int'(illegal_op), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_st = 0;

    // R-type: 0,1,6,7
    repeat (4) cyc(6'h00, 1'b1);
    // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4
    repeat (3) cyc(6'h23, 1'b1);
    repeat (2) cyc(6'h23, 1'b0);
    repeat (2) cyc(6'h23, 1'b1);
    // beq: 0,1,8
    repeat (3) cyc(6'h04, 1'b1);
    // Fetch stall for 3 cycles, then addi
    repeat (3) cyc(6'h08, 1'b0);
    repeat (4) cyc(6'h08, 1'b1);
    // Illegal opcode then jump
    repeat (2) cyc(6'h3F, 1'b1);
    repeat (3) cyc(6'h02, 1'b1);
    // sw with one wait cycle
    repeat (3) cyc(6'h2B, 1'b1);
    cyc(6'h2B, 1'b0);
    cyc(6'h2B, 1'b1);

    // Random opcodes and handshake every cycle.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) < 6) rop = legal_ops[$urandom_range(0, 5)];
      else rop = 6'($urandom_range(0, 63));
      cyc(rop, ($urandom_range(0, 9) < 7));
    end

    // Reach FETCH, then stall in MEMWR and reset asynchronously.
    for (int i = 0; i < 12 && m_st != 0; i++) cyc(6'h00, 1'b1);
    repeat (3) cyc(6'h2B, 1'b1);
    opcode    = 6'h2B;
    mem_ready = 1'b0;
    #2;
    chk("memwr_state", int'(state), 5);
    chk("memwr_we", int'(MemWrite), 1);
    reset = 1'b1;
    #1;
    chk("async_we", int'(MemWrite), 0);
    chk("async_state", int'(state), 0);
    chk("async_outs", int'(obs_out()), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_st = 0;
    repeat (6) cyc(6'h2B, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit instruction opcode and sequences fetch/decode/execute/memory/writeback steps.
- Drives all datapath enables and the 2-bit ALU opcode consumed by the downstream ALU control stage (00 add, 01 subtract, 10 decode funct).
- Memory accesses stall on a ready handshake.

Parameters:
- MEM_HANDSHAKE, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is treated as constant 1.
- OP_W, 6, opcode width (fixed at 6; present for lint checks only).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction[31:26] from the instruction register.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- PCWrite  output  1  unconditional PC write.
- Branch  output  1  PC write qualified by ALU zero.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  writeback data select: 0=ALUOut, 1=MDR.
- RegDst  output  1  destination select: 0=rt, 1=rd.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  0=PC, 1=register A.
- ALUSrcB  output  2  00=B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left by 2.
- PCSrc  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- ALUopcode  output  2  to the ALU control stage.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state  output  4  current state encoding (debug).

Behaviour:
- Reset: async, active-high. state=FETCH(0). Every registered output is 0. While reset is high, all combinational outputs are forced to 0. First fetch begins on the first rising edge after reset deasserts.
- States and their outputs (signals not listed are 0):
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUopcode=00, PCSrc=00. IRWrite and PCWrite equal mem_ready (Mealy). Stays in FETCH until mem_ready=1, then goes to DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUopcode=00 (branch target into ALUOut). Next state by opcode:
    - 0x23 lw or 0x2B sw -> MEMADR
    - 0x00 R-type -> EXECUTE
    - 0x04 beq -> BRANCH
    - 0x08 addi -> ADDIEX
    - 0x02 j -> JUMP
    - any other -> FETCH, with illegal_op=1 for exactly that DECODE cycle.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUopcode=00. Goes to MEMRD if opcode=0x23, else MEMWR.
  - MEMRD(3): MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. Waits for mem_ready, then goes to FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUopcode=10. Goes to ALUWB.
  - ALUWB(7): RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUopcode=01, Branch=1, PCSrc=01. Goes to FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUopcode=00. Goes to ADDIWB.
  - ADDIWB(10): RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
  - JUMP(11): PCWrite=1, PCSrc=10. Goes to FETCH.
- Encodings 12-15 are unreachable. If entered, the FSM returns to FETCH next cycle with all outputs 0.
- Latency in cycles, with mem_ready always 1:
  - R-type 4, addi 4, beq 3, j 3, sw 4, lw 5.
  - Each cycle mem_ready is low in a wait state adds one cycle.
- Opcode is sampled in DECODE and MEMADR only. It is ignored elsewhere.
- mem_ready high outside FETCH/MEMRD/MEMWR has no effect.
- Reset asserted mid-instruction returns the FSM to FETCH immediately, with no write enables asserted.
- Outputs other than the IRWrite/PCWrite Mealy terms are pure functions of state.

Test Plan:
- Reset, then opcode=0x00, mem_ready=1 -> states 0,1,6,7,0. ALUopcode=10 in EXECUTE. RegWrite=1, RegDst=1 in ALUWB only.
- opcode=0x23, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 throughout MEMRD. MemtoReg=1, RegWrite=1 in MEMWB.
- opcode=0x04 -> states 0,1,8,0. ALUopcode=01, Branch=1, PCSrc=01 in BRANCH. PCWrite=0 there.
- mem_ready=0 for 3 cycles in FETCH -> PCWrite=IRWrite=0 for those 3 cycles. Both are 1 for exactly one cycle when mem_ready rises, then DECODE.
- opcode=0x3F -> illegal_op pulses once in DECODE, next state FETCH, no RegWrite/MemWrite at any point. opcode=0x02 -> JUMP with PCSrc=10, PCWrite=1.
- Assert reset during MEMWR with mem_ready=0 -> MemWrite drops immediately. state=0 after reset deasserts, with no write enable asserted.
